// File: rtl/traffic_pkg.sv
// Shared light codes, state encodings and the light decode used by the
// highway/country intersection controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    L_G   = 2'b00,
    L_Y   = 2'b01,
    L_R   = 2'b10,
    L_OFF = 2'b11
  } light_t;

  typedef enum logic [2:0] {
    S_HG    = 3'd0,
    S_HY    = 3'd1,
    S_AR1   = 3'd2,
    S_CG    = 3'd3,
    S_CY    = 3'd4,
    S_AR2   = 3'd5,
    S_FLASH = 3'd6
  } state_t;

  typedef struct packed {
    light_t hwy;
    light_t cntry;
  } lights_t;

  // Unknown codes show all-red so a corrupted state can never show two greens.
  function automatic lights_t decode_lights(input state_t s, input logic phase);
    lights_t l;
    l.hwy   = L_R;
    l.cntry = L_R;
    case (s)
      S_HG:    l.hwy   = L_G;
      S_HY:    l.hwy   = L_Y;
      S_CG:    l.cntry = L_G;
      S_CY:    l.cntry = L_Y;
      S_FLASH: begin
        l.hwy   = phase ? L_OFF : L_Y;
        l.cntry = phase ? L_OFF : L_R;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic CLOCK_50,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge CLOCK_50 or posedge clear) begin
    if (clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/timed_traffic_ctrl.sv
// Timer-driven highway/country intersection controller with all-red clearance,
// country max-green limit and maintenance flash mode.
module timed_traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned HWY_MIN_G   = 10,
  parameter int unsigned CNTRY_MAX_G = 8,
  parameter int unsigned YEL_T       = 3,
  parameter int unsigned ALLRED_T    = 1
) (
  input  logic             CLOCK_50,
  input  logic             clear,
  input  logic             sensor,
  input  logic             flash,
  output logic [1:0]       hwy,
  output logic [1:0]       cntry,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] timer
);

  localparam logic [CNT_W:0] HWY_MIN_EL   = (CNT_W+1)'(HWY_MIN_G);
  localparam logic [CNT_W:0] CNTRY_MAX_EL = (CNT_W+1)'(CNTRY_MAX_G);
  localparam logic [CNT_W:0] YEL_EL       = (CNT_W+1)'(YEL_T);
  localparam logic [CNT_W:0] ALLRED_EL    = (CNT_W+1)'(ALLRED_T);

  logic tick;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .CLOCK_50(CLOCK_50),
    .clear   (clear),
    .tick    (tick)
  );

  logic             sensor_m_q, sensor_m_d, sensor_s_q, sensor_s_d;
  logic             flash_m_q, flash_m_d, flash_s_q, flash_s_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             phase_q, phase_d;
  light_t           hwy_q, hwy_d, cntry_q, cntry_d;
  lights_t          lights_d;
  logic [CNT_W:0]   el;

  always_comb begin
    sensor_m_d = sensor;
    sensor_s_d = sensor_m_q;
    flash_m_d  = flash;
    flash_s_d  = flash_m_q;

    el      = {1'b0, timer_q} + (CNT_W+1)'(1);
    state_d = state_q;
    phase_d = phase_q;

    // Flash entry needs no tick and overrides every timed transition.
    if (flash_s_q && state_q != S_FLASH) begin
      state_d = S_FLASH;
      phase_d = 1'b0;
    end else begin
      case (state_q)
        S_HG:    if (tick && sensor_s_q && el >= HWY_MIN_EL) state_d = S_HY;
        S_HY:    if (tick && el >= YEL_EL)                   state_d = S_AR1;
        S_AR1:   if (tick && el >= ALLRED_EL)                state_d = S_CG;
        S_CG:    if (tick && (!sensor_s_q || el >= CNTRY_MAX_EL)) state_d = S_CY;
        S_CY:    if (tick && el >= YEL_EL)                   state_d = S_AR2;
        S_AR2:   if (tick && el >= ALLRED_EL)                state_d = S_HG;
        S_FLASH: begin
          if (tick) begin
            if (!flash_s_q) state_d = S_AR2;
            else            phase_d = ~phase_q;
          end
        end
        default: state_d = S_HG;
      endcase
    end

    if (state_d != state_q)          timer_d = '0;
    else if (tick && timer_q != '1)  timer_d = timer_q + CNT_W'(1);
    else                             timer_d = timer_q;

    // Lights are decoded from next state so they register alongside it.
    lights_d = decode_lights(state_d, phase_d);
    hwy_d    = lights_d.hwy;
    cntry_d  = lights_d.cntry;
  end

  always_ff @(posedge CLOCK_50 or posedge clear) begin
    if (clear) begin
      sensor_m_q <= 1'b0;
      sensor_s_q <= 1'b0;
      flash_m_q  <= 1'b0;
      flash_s_q  <= 1'b0;
      state_q    <= S_HG;
      timer_q    <= '0;
      phase_q    <= 1'b0;
      hwy_q      <= L_G;
      cntry_q    <= L_R;
    end else begin
      sensor_m_q <= sensor_m_d;
      sensor_s_q <= sensor_s_d;
      flash_m_q  <= flash_m_d;
      flash_s_q  <= flash_s_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      phase_q    <= phase_d;
      hwy_q      <= hwy_d;
      cntry_q    <= cntry_d;
    end
  end

  assign hwy   = hwy_q;
  assign cntry = cntry_q;
  assign state = state_q;
  assign timer = timer_q;

endmodule

// File: tb/tb_timed_traffic_ctrl.sv
// Self-checking bench for timed_traffic_ctrl: vector table, directed corner
// sequences and randomized stimulus against a rule-level reference model.
module tb_timed_traffic_ctrl;

  logic       clk = 1'b0;
  logic       clear, sensor, flash;
  logic [1:0] hwy, cntry;
  logic [2:0] state;
  logic [7:0] timer;

  int checks   = 0;
  int failures = 0;

  timed_traffic_ctrl #(
    .TICK_DIV   (1),
    .CNT_W      (8),
    .HWY_MIN_G  (4),
    .CNTRY_MAX_G(3),
    .YEL_T      (2),
    .ALLRED_T   (1)
  ) dut (
    .CLOCK_50(clk),
    .clear   (clear),
    .sensor  (sensor),
    .flash   (flash),
    .hwy     (hwy),
    .cntry   (cntry),
    .state   (state),
    .timer   (timer)
  );

  always #5 clk = ~clk;

  // Reference model: ring of six timed phases (HG..AR2) plus flash (6).
  int NEED[6] = '{4, 2, 1, 3, 2, 1};
  int HW_L[6] = '{0, 1, 2, 2, 2, 2};
  int CT_L[6] = '{2, 2, 2, 0, 1, 2};
  int m_st, m_t, m_ph;
  bit ms1, ms2, mf1, mf2;

  typedef struct {
    bit sens;
    bit fl;
    int st;
    int hw;
    int ct;
    int tm;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_t = 0; m_ph = 0;
    ms1 = 0; ms2 = 0; mf1 = 0; mf2 = 0;
  endtask

  task automatic model_update();
    int nxt, el;
    if (clear) begin
      model_reset();
      return;
    end
    nxt = m_st;
    el  = m_t + 1;
    if (mf2 && m_st != 6) begin
      nxt = 6; m_ph = 0;
    end else if (m_st == 6) begin
      if (!mf2) nxt = 5;
      else      m_ph ^= 1;
    end else if (m_st == 0) begin
      if (ms2 && el >= NEED[0]) nxt = 1;
    end else if (m_st == 3) begin
      if (!ms2 || el >= NEED[3]) nxt = 4;
    end else if (el >= NEED[m_st]) begin
      nxt = (m_st + 1) % 6;
    end
    m_t  = (nxt != m_st) ? 0 : m_t + 1;
    m_st = nxt;
    ms2 = ms1; ms1 = sensor;
    mf2 = mf1; mf1 = flash;
  endtask

  task automatic compare_model();
    int eh, ec;
    eh = (m_st == 6) ? (m_ph ? 3 : 1) : HW_L[m_st];
    ec = (m_st == 6) ? (m_ph ? 3 : 2) : CT_L[m_st];
    chk("model_state", int'(state), m_st);
    chk("model_timer", int'(timer), (m_t > 255) ? 255 : m_t);
    chk("model_hwy",   int'(hwy),   eh);
    chk("model_cntry", int'(cntry), ec);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic run_to(input int st, input int limit, output int n);
    n = 0;
    while (int'(state) != st && n < limit) begin
      cyc();
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (state != 3'd6) begin
      checks++;
      if (hwy != 2'b10 && cntry != 2'b10) begin
        failures++;
        $display("FAIL no_conflict: hwy=%0d cntry=%0d state=%0d", hwy, cntry, state);
      end
    end
  end

  initial begin
    int n;
    tbl[0]  = '{1, 0, 0, 0, 2, 1};
    tbl[1]  = '{1, 0, 0, 0, 2, 2};
    tbl[2]  = '{1, 0, 0, 0, 2, 3};
    tbl[3]  = '{1, 0, 1, 1, 2, 0};
    tbl[4]  = '{1, 0, 1, 1, 2, 1};
    tbl[5]  = '{1, 0, 2, 2, 2, 0};
    tbl[6]  = '{1, 0, 3, 2, 0, 0};
    tbl[7]  = '{1, 0, 3, 2, 0, 1};
    tbl[8]  = '{1, 0, 3, 2, 0, 2};
    tbl[9]  = '{1, 0, 4, 2, 1, 0};
    tbl[10] = '{1, 0, 4, 2, 1, 1};
    tbl[11] = '{1, 0, 5, 2, 2, 0};
    tbl[12] = '{1, 0, 0, 0, 2, 0};
    tbl[13] = '{1, 0, 0, 0, 2, 1};
    tbl[14] = '{1, 0, 0, 0, 2, 2};
    tbl[15] = '{1, 0, 0, 0, 2, 3};
    tbl[16] = '{1, 0, 1, 1, 2, 0};

    clear = 1'b1; sensor = 1'b0; flash = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(state), 0);
    chk("reset_hwy",   int'(hwy),   0);
    chk("reset_cntry", int'(cntry), 2);
    chk("reset_timer", int'(timer), 0);

    // Full cycle with sensor held from reset release.
    clear = 1'b0;
    for (int i = 0; i < 17; i++) begin
      sensor = tbl[i].sens;
      flash  = tbl[i].fl;
      cyc();
      chk($sformatf("vec%0d_state", i), int'(state), tbl[i].st);
      chk($sformatf("vec%0d_hwy",   i), int'(hwy),   tbl[i].hw);
      chk($sformatf("vec%0d_cntry", i), int'(cntry), tbl[i].ct);
      chk($sformatf("vec%0d_timer", i), int'(timer), tbl[i].tm);
    end

    // Clear mid-CG returns to HG at once.
    run_to(3, 20, n);
    chk("reach_cg", int'(state), 3);
    clear = 1'b1;
    model_reset();
    #1;
    chk("clr_state", int'(state), 0);
    chk("clr_hwy",   int'(hwy),   0);
    chk("clr_cntry", int'(cntry), 2);
    chk("clr_timer", int'(timer), 0);
    cyc();
    clear = 1'b0; sensor = 1'b0;
    repeat (20) cyc();
    chk("idle_hg", int'(state), 0);

    // Short sensor pulse is not latched.
    do_reset();
    sensor = 1'b1;
    cyc();
    chk("pulse_timer", int'(timer), 1);
    sensor = 1'b0;
    repeat (20) cyc();
    chk("pulse_stays_hg", int'(state), 0);

    // Sensor dropped at CG entry.
    do_reset();
    sensor = 1'b1;
    run_to(3, 20, n);
    sensor = 1'b0;
    run_to(4, 10, n);
    chk("cg_to_cy_cycles", n, 3);
    repeat (2) cyc();
    chk("cy_to_ar2", int'(state), 5);
    cyc();
    chk("ar2_to_hg", int'(state), 0);

    // Flash from CG and recovery through all-red.
    do_reset();
    sensor = 1'b1;
    run_to(3, 20, n);
    flash = 1'b1;
    run_to(6, 10, n);
    chk("flash_entry_cycles", n, 3);
    chk("flash_p0_hwy", int'(hwy), 1);
    chk("flash_p0_cntry", int'(cntry), 2);
    cyc();
    chk("flash_p1_hwy", int'(hwy), 3);
    chk("flash_p1_cntry", int'(cntry), 3);
    cyc();
    chk("flash_p0b_hwy", int'(hwy), 1);
    flash = 1'b0;
    run_to(5, 10, n);
    chk("flash_exit_cycles", n, 3);
    chk("flash_exit_hwy", int'(hwy), 2);
    chk("flash_exit_cntry", int'(cntry), 2);
    cyc();
    chk("flash_exit_hg", int'(state), 0);

    // Timer saturation in a long HG, then request.
    do_reset();
    sensor = 1'b0;
    repeat (300) cyc();
    chk("timer_sat", int'(timer), 255);
    sensor = 1'b1;
    run_to(1, 10, n);
    chk("sat_to_hy_cycles", n, 3);

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0)   sensor = ~sensor;
      if ($urandom_range(0, 79) == 0)  flash  = ~flash;
      if ($urandom_range(0, 499) == 0) begin
        clear = 1'b1;
        cyc();
        clear = 1'b0;
      end else begin
        cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
